// File: rtl/stream_argmax.sv
// Streaming argmax: tracks the largest element of a vector and its first position,
// then presents value/index/count until the consumer takes the result.
module stream_argmax #(
    parameter int DATA_W  = 32,
    parameter int MAX_LEN = 256,
    parameter bit SIGNED  = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_value,
    output logic [$clog2(MAX_LEN)-1:0]  out_index,
    output logic [$clog2(MAX_LEN):0]    out_count,
    output logic                        out_ovf
);
    localparam int IDX_W = $clog2(MAX_LEN);
    localparam logic [IDX_W:0] LAST_CNT = (IDX_W+1)'(MAX_LEN);

    typedef enum logic {ACC, OUT} state_t;
    state_t state, state_nxt;

    logic [IDX_W:0]    cnt, cnt_nxt;
    logic [DATA_W-1:0] best, new_best;
    logic [IDX_W-1:0]  best_idx, new_idx;
    logic              xfer, gt, take, done;

    always_comb begin
        if (SIGNED) gt = $signed(in_data) > $signed(best);
        else        gt = in_data > best;
    end

    // first beat always wins; later beats only on a strict increase so ties keep the earliest index
    assign xfer     = in_valid && in_ready;
    assign take     = (cnt == '0) || gt;
    assign cnt_nxt  = cnt + 1'b1;
    assign done     = xfer && (in_last || (cnt_nxt == LAST_CNT));
    assign new_best = take ? in_data : best;
    assign new_idx  = take ? cnt[IDX_W-1:0] : best_idx;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ACC;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACC: begin
                in_ready = 1'b1;
                if (done) state_nxt = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ACC;
            end
            default: state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            best      <= '0;
            best_idx  <= '0;
            out_value <= '0;
            out_index <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            if (xfer) begin
                cnt      <= cnt_nxt;
                best     <= new_best;
                best_idx <= new_idx;
            end
            if (done) begin
                out_value <= new_best;
                out_index <= new_idx;
                out_count <= cnt_nxt;
                // truncation only when the length limit, not in_last, ended the vector
                out_ovf   <= !in_last;
            end
            if (out_valid && out_ready) cnt <= '0;
        end
    end
endmodule

// File: tb/tb_stream_argmax.sv
// Directed bench: three instances (signed, unsigned, MAX_LEN=4) driven from a vector table
// plus hand-written stall, truncation-carryover and reset sequences.
module tb_stream_argmax;
    logic clk = 1'b0;
    logic rst_n;
    logic [2:0] iv, ir, ov, ordy;
    logic [31:0] dat;
    logic lst;

    logic [31:0] va, vb, vc;
    logic [7:0]  ia, ib;
    logic [1:0]  ic;
    logic [8:0]  ca, cb;
    logic [2:0]  cc;
    logic [2:0]  ovf;

    logic [2:0][31:0] vals, idxs, cnts;
    assign vals[0] = va;
    assign vals[1] = vb;
    assign vals[2] = vc;
    assign idxs[0] = 32'(ia);
    assign idxs[1] = 32'(ib);
    assign idxs[2] = 32'(ic);
    assign cnts[0] = 32'(ca);
    assign cnts[1] = 32'(cb);
    assign cnts[2] = 32'(cc);

    always #5 clk = ~clk;

    stream_argmax #(.DATA_W(32), .MAX_LEN(256), .SIGNED(1'b1)) u_s (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(dat),
        .in_last(lst), .out_valid(ov[0]), .out_ready(ordy[0]), .out_value(va),
        .out_index(ia), .out_count(ca), .out_ovf(ovf[0]));

    stream_argmax #(.DATA_W(32), .MAX_LEN(256), .SIGNED(1'b0)) u_u (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(dat),
        .in_last(lst), .out_valid(ov[1]), .out_ready(ordy[1]), .out_value(vb),
        .out_index(ib), .out_count(cb), .out_ovf(ovf[1]));

    stream_argmax #(.DATA_W(32), .MAX_LEN(4), .SIGNED(1'b1)) u_m (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(dat),
        .in_last(lst), .out_valid(ov[2]), .out_ready(ordy[2]), .out_value(vc),
        .out_index(ic), .out_count(cc), .out_ovf(ovf[2]));

    typedef struct packed {
        logic [1:0]       sel;
        logic [3:0]       n;
        logic             lst;
        logic [5:0][31:0] d;
        logic [31:0]      ev, ei, ec;
        logic             eo;
    } vec_t;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int sel, input int n, input logic l,
                                input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                input logic [31:0] d3, input logic [31:0] d4, input logic [31:0] d5,
                                input logic [31:0] ev, input logic [31:0] ei, input logic [31:0] ec,
                                input logic eo);
        vec_t v;
        v.sel = 2'(sel); v.n = 4'(n); v.lst = l;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3; v.d[4] = d4; v.d[5] = d5;
        v.ev = ev; v.ei = ei; v.ec = ec; v.eo = eo;
        return v;
    endfunction

    // Offer one beat to instance sel; returns after the edge on which it transferred.
    task automatic send(input int sel, input logic [31:0] d, input logic l);
        logic ok;
        int n;
        ok = 1'b0;
        n = 0;
        iv[sel] = 1'b1; dat = d; lst = l;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = ir[sel];
            @(posedge clk);
            #1;
            n++;
        end
        iv[sel] = 1'b0; lst = 1'b0;
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_res(input int sel, input logic [31:0] ev, input logic [31:0] ei,
                           input logic [31:0] ec, input logic eo);
        chk("out_valid", 32'(ov[sel]), 32'd1);
        chk("out_value", vals[sel], ev);
        chk("out_index", idxs[sel], ei);
        chk("out_count", cnts[sel], ec);
        chk("out_ovf", 32'(ovf[sel]), 32'(eo));
    endtask

    task automatic accept(input int sel);
        ordy[sel] = 1'b1;
        @(posedge clk);
        #1;
        ordy[sel] = 1'b0;
        chk("valid_after_accept", 32'(ov[sel]), 32'd0);
        chk("ready_after_accept", 32'(ir[sel]), 32'd1);
    endtask

    vec_t tbl[8];

    initial begin
        iv = '0; ordy = '0; dat = '0; lst = 1'b0; rst_n = 1'b0;
        tbl[0] = mk(0, 5, 1, 32'd5, 32'hFFFF_FFFD, 32'd9, 32'd9, 32'd2, 0, 32'd9, 32'd2, 32'd5, 0);
        tbl[1] = mk(1, 5, 1, 32'd5, 32'hFFFF_FFFD, 32'd9, 32'd9, 32'd2, 0, 32'hFFFF_FFFD, 32'd1, 32'd5, 0);
        tbl[2] = mk(0, 1, 1, 32'h8000_0000, 0, 0, 0, 0, 0, 32'h8000_0000, 32'd0, 32'd1, 0);
        tbl[3] = mk(0, 3, 1, 32'd4, 32'd4, 32'd4, 0, 0, 0, 32'd4, 32'd0, 32'd3, 0);
        tbl[4] = mk(0, 3, 1, 32'hFFFF_FFFB, 32'hFFFF_FFFE, 32'hFFFF_FFF7, 0, 0, 0, 32'hFFFF_FFFE, 32'd1, 32'd3, 0);
        tbl[5] = mk(2, 4, 1, 32'd1, 32'd2, 32'd3, 32'd4, 0, 0, 32'd4, 32'd3, 32'd4, 0);
        tbl[6] = mk(1, 3, 1, 32'd1, 32'h7FFF_FFFF, 32'h8000_0000, 0, 0, 0, 32'h8000_0000, 32'd2, 32'd3, 0);
        tbl[7] = mk(2, 4, 0, 32'd1, 32'd2, 32'd3, 32'd4, 0, 0, 32'd4, 32'd3, 32'd4, 1);

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int s = 0; s < 3; s++) begin
            chk("rst_valid", 32'(ov[s]), 32'd0);
            chk("rst_ready", 32'(ir[s]), 32'd1);
            chk("rst_value", vals[s], 32'd0);
            chk("rst_index", idxs[s], 32'd0);
            chk("rst_count", cnts[s], 32'd0);
            chk("rst_ovf", 32'(ovf[s]), 32'd0);
        end

        for (int i = 0; i < 8; i++) begin
            for (int b = 0; b < int'(tbl[i].n); b++) begin
                send(int'(tbl[i].sel), tbl[i].d[b], tbl[i].lst && (b == int'(tbl[i].n) - 1));
                if (b < int'(tbl[i].n) - 1) chk("valid_mid_vector", 32'(ov[tbl[i].sel]), 32'd0);
            end
            chk_res(int'(tbl[i].sel), tbl[i].ev, tbl[i].ei, tbl[i].ec, tbl[i].eo);
            accept(int'(tbl[i].sel));
        end

        // beats 5 and 6 after a truncated vector form the next vector
        send(2, 32'd5, 1'b0);
        send(2, 32'd6, 1'b1);
        chk_res(2, 32'd6, 32'd1, 32'd2, 1'b0);
        accept(2);

        // result held while out_ready is low; offered beats must not be consumed
        send(0, 32'd3, 1'b0);
        send(0, 32'd8, 1'b1);
        iv[0] = 1'b1; dat = 32'd100; lst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk_res(0, 32'd8, 32'd1, 32'd2, 1'b0);
            chk("stall_in_ready", 32'(ir[0]), 32'd0);
        end
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        ordy[0] = 1'b0; iv[0] = 1'b0; lst = 1'b0;
        chk("stall_release_valid", 32'(ov[0]), 32'd0);
        chk("stall_release_ready", 32'(ir[0]), 32'd1);
        send(0, 32'd1, 1'b1);
        chk_res(0, 32'd1, 32'd0, 32'd1, 1'b0);
        accept(0);

        // reset mid-vector discards the partial vector
        send(0, 32'd50, 1'b0);
        send(0, 32'd60, 1'b0);
        send(0, 32'd70, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_valid", 32'(ov[0]), 32'd0);
        chk("midrst_ready", 32'(ir[0]), 32'd1);
        chk("midrst_value", vals[0], 32'd0);
        send(0, 32'd7, 1'b0);
        chk("midrst_no_valid", 32'(ov[0]), 32'd0);
        send(0, 32'd1, 1'b1);
        chk_res(0, 32'd7, 32'd0, 32'd2, 1'b0);
        accept(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/stream_argmax.md
STREAM_ARGMAX -- requirements
Module: stream_argmax

Interface
REQ-001 SHALL have parameter DATA_W, default 32, element width in bits.
REQ-002 SHALL have parameter MAX_LEN, default 256, maximum elements per vector (>=2).
REQ-003 SHALL have parameter SIGNED, default 1: 1 = two's-complement compare, 0 = unsigned compare.
REQ-004 SHALL have localparam IDX_W = $clog2(MAX_LEN).
REQ-005 SHALL use one clock and a synchronous, active-low reset.
REQ-006 Ports, in order (name  direction  width  meaning):
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  element offered.
- in_ready  output  1  block can accept an element.
- in_data  input  DATA_W  element value.
- in_last  input  1  element is the final one of the vector.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_value  output  DATA_W  maximum element value.
- out_index  output  IDX_W  position of the maximum, 0-based.
- out_count  output  IDX_W+1  elements in the vector.
- out_ovf  output  1  vector was truncated at MAX_LEN.

Function
REQ-007 SHALL implement a two-state FSM: ACC (collecting) and OUT (presenting the result).
REQ-008 in_ready SHALL be 1 in ACC and 0 in OUT.
REQ-009 An input beat SHALL transfer only when in_valid && in_ready; in_data and in_last SHALL be ignored otherwise.
REQ-010 The first beat of a vector (count==0) SHALL load the best value and set best index 0, independent of value.
REQ-011 Each later beat SHALL replace the best value and index (index = current count) only if in_data > best, strictly; ties SHALL keep the earliest index.
REQ-012 Comparison SHALL be signed when SIGNED=1 and unsigned when SIGNED=0, over the full DATA_W.
REQ-013 Count SHALL increment by 1 on every transferred beat.
REQ-014 On a transferred beat with in_last=1, or on the beat that makes count equal MAX_LEN, the FSM SHALL go to OUT on that edge, with that beat included in the result.
REQ-015 out_ovf SHALL be 1 exactly when the end was forced by MAX_LEN while in_last=0; a beat with in_last=1 at count MAX_LEN SHALL give out_ovf=0.
REQ-016 out_valid SHALL rise the cycle after the final beat transfers (latency 1); out_count SHALL then equal the number of transferred beats.
REQ-017 In OUT, out_valid, out_value, out_index, out_count and out_ovf SHALL be held stable until out_ready=1.
REQ-018 On out_valid && out_ready, the FSM SHALL return to ACC and clear count.
REQ-019 out_valid SHALL drop on the edge after acceptance; in_ready SHALL rise the same cycle, with no same-cycle input bypass.
REQ-020 Result outputs SHALL retain their last values in ACC; only out_valid qualifies them.
REQ-021 Peak throughput SHALL be one L-element vector per L+1 cycles with out_ready held at 1.

Reset
REQ-022 When rst_n=0 at a rising edge: FSM = ACC, count = 0, best = 0, out_valid = 0, out_value = 0, out_index = 0, out_count = 0, out_ovf = 0.
REQ-023 in_ready SHALL be 1 in the first cycle after reset release.
REQ-024 Reset during a partial vector or during OUT SHALL discard all state; no result for that vector is produced.

Verification
REQ-025 Bench SHALL cover:
- SIGNED=1, DATA_W=32: beats 5, -3, 9, 9, 2 (last on 2) -> one cycle later out_valid=1, out_value=9, out_index=2, out_count=5, out_ovf=0.
- SIGNED=0, same beats -> out_value=0xFFFFFFFD, out_index=1.
- Single beat 0x80000000 with in_last=1, SIGNED=1 -> out_value=0x80000000, out_index=0, out_count=1.
- MAX_LEN=4, six beats 1,2,3,4,5,6 with no in_last -> result 4, index 3, count 4, ovf=1; beats 5,6 start the next vector.
- out_ready held 0 for 10 cycles -> outputs stable, in_ready=0, in_valid beats not consumed; out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
- rst_n=0 after 3 of 5 beats -> no out_valid; a fresh vector 7,1 -> out_value=7, out_index=0, out_count=2.
